// File: rtl/smvm_pkg.sv
/*------------------------------------------------------------------------------
 * smvm_pkg: shared types for the sparse matrix-vector nonzero stream.
 * Revision: 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

package smvm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] value;
      logic [31:0] col;
      logic [31:0] row;
   } coo_entry_t;

   // A row index equal to the row count marks a lane as finished.
   function automatic logic [31:0] sentinel_row(input int unsigned num_rows);
      return 32'(num_rows);
   endfunction

endpackage

`default_nettype wire

// File: rtl/coo_lane_fetch.sv
/*------------------------------------------------------------------------------
 * coo_lane_fetch: one lane's read strobe, data-valid delay and output register.
 * Revision: 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module coo_lane_fetch
   import smvm_pkg::*;
#(
   parameter int unsigned NUM_ROWS = 128,
   parameter int unsigned ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              clear,
   input  logic [ADDR_W:0]   len_in,
   input  logic              issue,
   input  logic [ADDR_W:0]   beat,
   input  logic              out_beat,
   input  logic              park,
   input  logic [31:0]       mem_value,
   input  logic [31:0]       mem_col,
   input  logic [31:0]       mem_row,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       value,
   output logic [31:0]       col,
   output logic [31:0]       row,
   output logic              bad
);

   localparam logic [31:0] SENT_ROW = sentinel_row(NUM_ROWS);
   localparam coo_entry_t  SENT_ENTRY = '{value: 32'd0, col: 32'd0, row: SENT_ROW};

   logic [ADDR_W:0] len_q;
   logic            valid_d;
   coo_entry_t      rd_entry;
   coo_entry_t      out_q;
   logic            row_bad;

   assign rd_entry = '{value: mem_value, col: mem_col, row: mem_row};
   assign row_bad  = (rd_entry.row >= SENT_ROW);

   assign value = out_q.value;
   assign col   = out_q.col;
   assign row   = out_q.row;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         len_q    <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         valid_d  <= 1'b0;
         out_q    <= '0;
         bad      <= 1'b0;
      end else begin
         if (clear) begin
            len_q <= len_in;
         end
         mem_rd <= issue && (beat < len_q);
         if (issue) begin
            mem_addr <= beat[ADDR_W-1:0];
         end
         valid_d <= mem_rd;

         // An out-of-range row is zeroed so the accumulator never sees an early finish.
         if (out_beat) begin
            if (!valid_d) begin
               out_q <= SENT_ENTRY;
            end else if (row_bad) begin
               out_q <= '{value: 32'd0, col: rd_entry.col, row: 32'd0};
            end else begin
               out_q <= rd_entry;
            end
         end else if (park) begin
            out_q <= SENT_ENTRY;
         end

         if (clear) begin
            bad <= 1'b0;
         end else if (out_beat && valid_d && row_bad) begin
            bad <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/coo_stream_source.sv
/*------------------------------------------------------------------------------
 * coo_stream_source: drives the lock-step COO channel bus from per-lane memories.
 * Revision: 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module coo_stream_source
   import smvm_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned NUM_ROWS     = 128,
   parameter int unsigned ADDR_W       = 10
) (
   input  logic                               clk,
   input  logic                               rst_l,
   input  logic                               start,
   input  logic [NUM_CHANNELS*(ADDR_W+1)-1:0] nnz_len,
   output logic [NUM_CHANNELS-1:0]            mem_rd,
   output logic [NUM_CHANNELS*ADDR_W-1:0]     mem_addr,
   input  logic [NUM_CHANNELS*32-1:0]         mem_value,
   input  logic [NUM_CHANNELS*32-1:0]         mem_col,
   input  logic [NUM_CHANNELS*32-1:0]         mem_row,
   output logic [NUM_CHANNELS*32-1:0]         values,
   output logic [NUM_CHANNELS*32-1:0]         col_id,
   output logic [NUM_CHANNELS*32-1:0]         row_id,
   output logic                               rdy,
   output logic                               busy,
   output logic                               done,
   output logic                               bad_row
);

   localparam logic [ADDR_W:0] LEN_CAP = {1'b1, {ADDR_W{1'b0}}};

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_W:0]         beat;
   logic [ADDR_W:0]         maxlen;
   logic [ADDR_W:0]         start_max;
   logic [ADDR_W:0]         start_len [NUM_CHANNELS];
   logic                    accept;
   logic                    issue;
   logic                    issue_d;
   logic                    beat_d;
   logic                    drain_seen;
   logic                    drain_exit;
   logic [NUM_CHANNELS-1:0] lane_bad;

   assign accept  = start && ((state == IDLE) || (state == DONE));
   assign issue   = (state == FETCH) && (beat < maxlen);
   // drain_seen adds the one bubble a zero-length stream needs to match normal latency.
   assign drain_exit = (state == DRAIN) && drain_seen && !issue_d && !beat_d;
   assign busy    = (state == FETCH) || (state == DRAIN);
   assign done    = (state == DONE);
   assign bad_row = |lane_bad;

   always_comb begin
      start_max = '0;
      for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
         if (start_len[k] > start_max) begin
            start_max = start_len[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            if ((maxlen == '0) || (beat == maxlen - 1'b1)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_exit) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         beat       <= '0;
         maxlen     <= '0;
         issue_d    <= 1'b0;
         beat_d     <= 1'b0;
         drain_seen <= 1'b0;
         rdy        <= 1'b0;
      end else begin
         if (accept) begin
            beat   <= '0;
            maxlen <= start_max;
         end else if (issue) begin
            beat <= beat + 1'b1;
         end
         issue_d    <= issue;
         beat_d     <= issue_d;
         drain_seen <= (state == DRAIN);
         rdy        <= beat_d;
      end
   end

   for (genvar k = 0; k < int'(NUM_CHANNELS); k++) begin : g_lane
      logic [ADDR_W:0] raw_len;
      assign raw_len      = nnz_len[k*(ADDR_W+1) +: (ADDR_W+1)];
      assign start_len[k] = (raw_len > LEN_CAP) ? LEN_CAP : raw_len;

      coo_lane_fetch #(
         .NUM_ROWS (NUM_ROWS),
         .ADDR_W   (ADDR_W)
      ) u_lane (
         .clk       (clk),
         .rst_l     (rst_l),
         .clear     (accept),
         .len_in    (start_len[k]),
         .issue     (issue),
         .beat      (beat),
         .out_beat  (beat_d),
         .park      (drain_exit),
         .mem_value (mem_value[k*32 +: 32]),
         .mem_col   (mem_col[k*32 +: 32]),
         .mem_row   (mem_row[k*32 +: 32]),
         .mem_rd    (mem_rd[k]),
         .mem_addr  (mem_addr[k*ADDR_W +: ADDR_W]),
         .value     (values[k*32 +: 32]),
         .col       (col_id[k*32 +: 32]),
         .row       (row_id[k*32 +: 32]),
         .bad       (lane_bad[k])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_coo_stream_source.sv
/*------------------------------------------------------------------------------
 * tb_coo_stream_source: directed stimulus checked against a beat-level model.
 * Revision: 1.0
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_coo_stream_source;

   localparam int NCH   = 4;
   localparam int AW    = 10;
   localparam int NR    = 128;
   localparam int DEPTH = 16;

   logic                    clk = 1'b0;
   logic                    rst_l = 1'b0;
   logic                    start = 1'b0;
   logic [NCH*(AW+1)-1:0]   nnz_len = '0;
   logic [NCH-1:0]          mem_rd;
   logic [NCH*AW-1:0]       mem_addr;
   logic [NCH*32-1:0]       mem_value = '0;
   logic [NCH*32-1:0]       mem_col = '0;
   logic [NCH*32-1:0]       mem_row = '0;
   logic [NCH*32-1:0]       values;
   logic [NCH*32-1:0]       col_id;
   logic [NCH*32-1:0]       row_id;
   logic                    rdy;
   logic                    busy;
   logic                    done;
   logic                    bad_row;

   int passed = 0;
   int total  = 0;
   int ecount = 0;

   logic [31:0] img_val [NCH][DEPTH];
   logic [31:0] img_col [NCH][DEPTH];
   logic [31:0] img_row [NCH][DEPTH];

   // Model of the current stream: start edge, lane lengths, first bad beat.
   bit running   = 1'b0;
   bit prev_sent = 1'b0;
   int T  = 0;
   int m  = 0;
   int fb = -1;
   int L [NCH];

   coo_stream_source #(
      .NUM_CHANNELS (NCH),
      .NUM_ROWS     (NR),
      .ADDR_W       (AW)
   ) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .start     (start),
      .nnz_len   (nnz_len),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_value (mem_value),
      .mem_col   (mem_col),
      .mem_row   (mem_row),
      .values    (values),
      .col_id    (col_id),
      .row_id    (row_id),
      .rdy       (rdy),
      .busy      (busy),
      .done      (done),
      .bad_row   (bad_row)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecount <= ecount + 1;

   // Entry memories: one-cycle read latency, junk on the bus when not read.
   always @(posedge clk) begin
      for (int k = 0; k < NCH; k++) begin
         if (mem_rd[k]) begin
            mem_value[k*32 +: 32] <= img_val[k][int'(mem_addr[k*AW +: AW]) % DEPTH];
            mem_col[k*32 +: 32]   <= img_col[k][int'(mem_addr[k*AW +: AW]) % DEPTH];
            mem_row[k*32 +: 32]   <= img_row[k][int'(mem_addr[k*AW +: AW]) % DEPTH];
         end else begin
            mem_value[k*32 +: 32] <= 32'hDEAD_0000 + 32'(k);
            mem_col[k*32 +: 32]   <= 32'h0000_BEEF;
            mem_row[k*32 +: 32]   <= 32'd5;
         end
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [95:0] lane_expect(input int k, input int b);
      if (b >= L[k]) return {32'd0, 32'd0, 32'(NR)};
      if (img_row[k][b] >= 32'(NR)) return {32'd0, img_col[k][b], 32'd0};
      return {img_val[k][b], img_col[k][b], img_row[k][b]};
   endfunction

   task automatic fill_std();
      for (int k = 0; k < NCH; k++) begin
         for (int b = 0; b < DEPTH; b++) begin
            img_val[k][b] = 32'h1000 * 32'(k + 1) + 32'(b);
            img_col[k][b] = 32'(7 * k + b);
            img_row[k][b] = 32'(3 * k + b);
         end
      end
   endtask

   always @(negedge clk) begin : compare
      int rel;
      logic [NCH*32-1:0] ev, ec, er;
      logic [NCH*AW-1:0] ea;
      logic [NCH-1:0]    erd;
      logic [95:0]       e;
      logic              erdy, ebusy, edone, ebad;
      ev = '0; ec = '0; er = '0; ea = '0; erd = '0;
      erdy = 1'b0; ebusy = 1'b0; edone = 1'b0; ebad = 1'b0; rel = 0;
      if (running && rst_l) begin
         rel   = ecount - T;
         erdy  = (rel >= 3) && (rel < 3 + m);
         ebusy = (rel < 3 + m);
         edone = !ebusy;
         ebad  = (fb >= 0) && (rel >= 3 + fb);
         for (int k = 0; k < NCH; k++) begin
            erd[k] = (rel >= 1) && (rel <= m) && (rel - 1 < L[k]);
            ea[k*AW +: AW] = AW'(rel - 1);
            if (erdy) e = lane_expect(k, rel - 3);
            else if (edone || prev_sent) e = {32'd0, 32'd0, 32'(NR)};
            else e = '0;
            ev[k*32 +: 32] = e[95:64];
            ec[k*32 +: 32] = e[63:32];
            er[k*32 +: 32] = e[31:0];
         end
      end
      check("rdy", rdy, erdy);
      check("busy", busy, ebusy);
      check("done", done, edone);
      check("bad_row", bad_row, ebad);
      check("mem_rd", mem_rd, erd);
      check("values", values, ev);
      check("col_id", col_id, ec);
      check("row_id", row_id, er);
      if (running && rst_l && rel >= 1 && rel <= m) check("mem_addr", mem_addr, ea);
   end

   task automatic pulse_start(input int l0, input int l1, input int l2, input int l3);
      int lens [NCH];
      lens = '{l0, l1, l2, l3};
      @(negedge clk);
      #2;
      nnz_len = {11'(l3), 11'(l2), 11'(l1), 11'(l0)};
      start   = 1'b1;
      if (!running || (ecount - T >= 3 + m)) begin
         prev_sent = running;
         running   = 1'b1;
         T  = ecount + 1;
         m  = 0;
         fb = -1;
         for (int k = 0; k < NCH; k++) begin
            L[k] = lens[k];
            if (lens[k] > m) m = lens[k];
         end
         for (int b = 0; b < m && fb < 0; b++) begin
            for (int k = 0; k < NCH; k++) begin
               if (b < L[k] && img_row[k][b] >= 32'(NR)) fb = b;
            end
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cnt, output int reld);
      cnt  = 0;
      reld = -1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (rdy) cnt++;
         if (done) begin
            reld = ecount - T;
            break;
         end
      end
      if (reld < 0) check("wait_done_timeout", done, 1);
   endtask

   initial begin
      int cnt;
      int rd;
      fill_std();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst_l = 1'b1;
      @(posedge clk);
      #1;
      check("reset_row_id", row_id, '0);
      check("reset_rdy", rdy, 0);
      check("reset_busy", busy, 0);

      // Equal lengths: exact first beat and sentinel parking.
      pulse_start(3, 3, 3, 3);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("t1_first_rdy", rdy, 1);
      check("t1_first_rows", row_id, {32'd9, 32'd6, 32'd3, 32'd0});
      check("t1_first_val0", values[31:0], 32'h1000);
      wait_done(cnt, rd);
      check("t1_rest_beats", cnt, 2);
      check("t1_done_at", rd, 6);
      check("t1_sentinel", row_id, {4{32'd128}});

      // Ragged lengths.
      pulse_start(4, 1, 0, 2);
      wait_done(cnt, rd);
      check("t2_beats", cnt, 4);
      check("t2_done_at", rd, 7);

      // Empty stream.
      pulse_start(0, 0, 0, 0);
      wait_done(cnt, rd);
      check("t3_beats", cnt, 0);
      check("t3_done_at", rd, 3);
      check("t3_sentinel", row_id, {4{32'd128}});

      // Out-of-range row on lane 0, beat 1.
      img_row[0][1] = 32'd200;
      img_val[0][1] = 32'd5;
      pulse_start(3, 3, 3, 3);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("t4_bad_row_id", row_id[31:0], 32'd0);
      check("t4_bad_value", values[31:0], 32'd0);
      check("t4_bad_col", col_id[31:0], 32'd1);
      check("t4_bad_flag", bad_row, 1);
      wait_done(cnt, rd);
      check("t4_bad_held", bad_row, 1);
      fill_std();

      // Start while busy is ignored; restart from DONE.
      pulse_start(4, 1, 0, 2);
      check("t5_bad_cleared", bad_row, 0);
      pulse_start(1, 1, 1, 1);
      wait_done(cnt, rd);
      check("t5_beats", cnt, 4);
      check("t5_done_at", rd, 7);
      pulse_start(1, 0, 0, 0);
      wait_done(cnt, rd);
      check("t5b_beats", cnt, 1);
      check("t5b_done_at", rd, 4);

      // Asynchronous reset mid-stream.
      pulse_start(3, 3, 3, 3);
      repeat (3) @(posedge clk);
      #2;
      rst_l   = 1'b0;
      running = 1'b0;
      #1;
      check("t6_rst_rdy", rdy, 0);
      check("t6_rst_row", row_id, '0);
      check("t6_rst_val", values, '0);
      check("t6_rst_rd", mem_rd, '0);
      check("t6_rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_l = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t6_idle_row", row_id, '0);
      pulse_start(2, 2, 2, 2);
      wait_done(cnt, rd);
      check("t6_beats", cnt, 2);
      check("t6_done_at", rd, 5);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/coo_stream_source.md
Name: coo_stream_source

Overview:
- Transmit side of the sparse-matrix nonzero stream. Reads COO entries (value, col, row) from NUM_CHANNELS per-channel entry memories with a one-cycle read latency.
- Drives the lock-step channel bus (values/col_id/row_id/rdy) consumed by the row accumulator.
- After the last beat, parks every channel on the end-of-stream sentinel so the accumulator can detect completion.

Parameters:
NUM_CHANNELS, 4, number of parallel lanes
NUM_ROWS, 128, matrix rows; row_id >= NUM_ROWS means lane finished
ADDR_W, 10, entry-memory address width per channel

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a stream when idle
nnz_len  in  NUM_CHANNELS x (ADDR_W+1)  entries per lane, sampled on accepted start
mem_rd  out  NUM_CHANNELS  per-lane read strobe
mem_addr  out  NUM_CHANNELS x ADDR_W  per-lane read address
mem_value  in  NUM_CHANNELS x 32  read data, valid the cycle after mem_rd
mem_col  in  NUM_CHANNELS x 32  read data, same timing
mem_row  in  NUM_CHANNELS x 32  read data, same timing
values  out  NUM_CHANNELS x 32  matrix value per lane
col_id  out  NUM_CHANNELS x 32  column index per lane
row_id  out  NUM_CHANNELS x 32  row index per lane, or sentinel
rdy  out  1  beat valid for all lanes
busy  out  1  high from accepted start until done
done  out  1  level; stream complete, sentinel parked
bad_row  out  1  sticky; a memory entry had row >= NUM_ROWS

Behaviour:
- Reset (async, any time, including mid-stream). All outputs go to 0: values, col_id, row_id, rdy, mem_rd, mem_addr, busy, done, bad_row. State goes to IDLE.
- Outputs are not sentinel in IDLE, so the accumulator does not finish early.
- States:
  - IDLE: start goes to FETCH. Latch nnz_len, saturating each lane to 2^ADDR_W. Clear beat counter and bad_row. Set busy.
  - FETCH: one cycle per beat b = 0..maxlen-1, where maxlen = max latched length.
    - Registered mem_rd[k] = (b < len[k]); mem_addr[k] = b.
    - lane_valid[k] is delayed one cycle to align with returned memory data.
    - After issuing beat maxlen-1, go to DRAIN. If maxlen = 0, go to DRAIN immediately with no reads.
  - DRAIN: wait for the last in-flight beat to be registered onto the outputs, then go to DONE.
  - DONE: every lane has row_id = NUM_ROWS, values = 0, col_id = 0, rdy = 0. done = 1, busy = 0. Hold until reset or start. start re-enters FETCH and clears done; outputs revert per beat.
- Output register, beat b:
  - rdy = 1.
  - Lane with valid data: values/col_id/row_id = memory data.
  - Lane past its length: row_id = NUM_ROWS, values = 0, col_id = 0.
  - Between beats and after the stream, rdy = 0.
- Latency:
  - start sampled at edge T: mem_rd at T+1, data at T+2, first rdy at T+3.
  - Beats are contiguous; rdy is high exactly maxlen consecutive cycles.
  - The cycle after the last rdy, all lanes show sentinel and done = 1.
  - maxlen = 0: sentinel and done at T+3, rdy never asserted.
- Bad entry (mem_row >= NUM_ROWS on a valid lane):
  - Emit row_id = 0, values = 0, col_id = mem_col. This avoids a false mid-stream finish.
  - Set bad_row; it stays set until the next accepted start or reset.
- start while busy is ignored; latched lengths are unchanged.
- Widths: beat counter is ADDR_W+1 bits. Comparisons are unsigned. Sentinel is the 32-bit zero-extended NUM_ROWS.

Decomposition:
- Shared package smvm_pkg holds:
  - state_t enum {IDLE, FETCH, DRAIN, DONE}
  - coo_entry_t struct {value, col, row}, 32 bits each
  - function sentinel_row(NUM_ROWS)
- Sub-module coo_lane_fetch, one per lane via generate. Contains the read-strobe register, the valid delay, and the output register with sentinel/bad-row substitution.
- The top level owns the FSM, beat counter, maxlen, busy/done, and the OR of per-lane bad flags.

Test Plan:
- len {3,3,3,3}, rows 0..11 in memory, start at T → rdy high T+3..T+5 with exact entries; T+6 all row_id = 128, rdy = 0, done = 1.
- len {4,1,0,2} → 4 beats. Lane 2 is sentinel every beat. Lane 1 is sentinel on beats 1-3. Lane 3 is sentinel on beats 2-3. mem_rd per lane matches lengths.
- len {0,0,0,0} → no mem_rd, no rdy; T+3 all lanes row_id = 128, done = 1.
- Lane 0, beat 1 memory row = 200, value = 5 → emitted row_id = 0, values = 0; bad_row = 1 and held through done; cleared on next start.
- start pulsed again mid-FETCH → ignored, beat count unchanged. Second start in DONE with len {1,0,0,0} → one beat, then done again.
- rst_l low mid-stream → all outputs 0 immediately (async); after release, idle with row_id = 0, rdy = 0 until start.
